// File: rtl/smg_pkg.sv
// smg_pkg: shared constants and types for the seven-segment channel scheduler
package smg_pkg;
  localparam int NUM_W = 20;
  localparam logic [NUM_W-1:0] SMG_MAX = 20'd999999;
  localparam int DWELL_DEFAULT = 200_000_000;
  localparam int SETTLE_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DWELL} state_t;
endpackage

// File: rtl/smg_channel_scheduler_rr_pick.sv
// rr_pick: first set mask bit searching start+1 upward cyclically, start itself checked last
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    found = |mask;
    idx = start;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(start) + k) % N);
      if (mask[j]) idx = j;
    end
  end
endmodule

// File: rtl/smg_channel_scheduler.sv
// smg_channel_scheduler: shares one 6-digit display driver between NUM_CH sources with
// round-robin dwell rotation, urgent preemption, data refresh and a post-load settle window
module smg_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int NUM_W = smg_pkg::NUM_W,
  parameter int DWELL_CYCLES = smg_pkg::DWELL_DEFAULT,
  parameter int SETTLE_CYCLES = smg_pkg::SETTLE_DEFAULT,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_urgent,
  input  logic [NUM_CH*NUM_W-1:0] ch_data,
  input  logic                    hold,
  output logic                    number_en,
  output logic [NUM_W-1:0]        number,
  output logic [CH_W-1:0]         cur_ch,
  output logic                    busy,
  output logic                    idle
);
  import smg_pkg::*;
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t state, state_n;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [SW-1:0] settle_cnt;
  logic [NUM_W-1:0] shown_r;
  logic [NUM_W-1:0] data [NUM_CH];
  logic zero_r, refresh_r, go, sel_zero, sel_refresh;
  logic [CH_W-1:0] sel, rot_start, rot_idx, urg_idx;
  logic rot_found, urg_found, self_urg;
  logic [NUM_CH-1:0] urg_mask;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign data[i] = ch_data[i*NUM_W +: NUM_W];
  end

  // In IDLE the rotation picker doubles as a lowest-valid-index search
  assign rot_start = state == IDLE ? CH_W'(NUM_CH - 1) : cur_ch;
  assign urg_mask = ch_urgent & ch_valid & ~(NUM_CH'(1) << cur_ch);
  assign self_urg = ch_urgent[cur_ch] & ch_valid[cur_ch];

  rr_pick #(.N(NUM_CH), .W(CH_W)) u_rot (
    .mask(ch_valid), .start(rot_start), .found(rot_found), .idx(rot_idx)
  );
  rr_pick #(.N(NUM_CH), .W(CH_W)) u_urg (
    .mask(urg_mask), .start(CH_W'(NUM_CH - 1)), .found(urg_found), .idx(urg_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dwell_cnt <= '0;
      settle_cnt <= '0;
      shown_r <= '0;
      number <= '0;
      cur_ch <= '0;
      zero_r <= 1'b0;
      refresh_r <= 1'b0;
    end else begin
      state <= state_n;
      dwell_cnt <= dwell_n;
      settle_cnt <= state == SETTLE && settle_cnt != SETTLE_LAST ? settle_cnt + 1'b1 : '0;
      if (go) begin
        cur_ch <= sel;
        number <= sel_zero ? '0 : data[sel];
        shown_r <= sel_zero ? '0 : data[sel];
        zero_r <= sel_zero;
        refresh_r <= sel_refresh;
      end
    end
  end

  always_comb begin
    state_n = state;
    go = 1'b0;
    sel = cur_ch;
    sel_zero = 1'b0;
    sel_refresh = 1'b0;
    case (state)
      IDLE: begin
        go = rot_found;
        sel = rot_idx;
      end
      LOAD: state_n = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) state_n = zero_r ? IDLE : DWELL;
      DWELL:
        if (!ch_valid[cur_ch]) begin
          go = 1'b1;
          sel = rot_found ? rot_idx : cur_ch;
          sel_zero = !rot_found;
        end else if (!hold && urg_found) begin
          go = 1'b1;
          sel = urg_idx;
        end else if (data[cur_ch] != shown_r) begin
          go = 1'b1;
          sel_refresh = 1'b1;
        end else if (!hold && dwell_cnt == DWELL_LAST && rot_idx != cur_ch) begin
          go = 1'b1;
          sel = rot_idx;
        end
      default: ;
    endcase
    if (go) state_n = LOAD;
  end

  // A refresh keeps the dwell deadline running through its own load and settle
  assign dwell_n = state == IDLE ? '0 :
                   state == DWELL ? (go && !sel_refresh ? '0 :
                                     hold ? dwell_cnt :
                                     self_urg ? '0 :
                                     dwell_cnt == DWELL_LAST ? (sel_refresh ? dwell_cnt : '0) :
                                     dwell_cnt + 1'b1) :
                   refresh_r && !hold && dwell_cnt != DWELL_LAST ? dwell_cnt + 1'b1 : dwell_cnt;

  always_comb begin
    number_en = state == LOAD;
    busy = state == LOAD || state == SETTLE;
    idle = state == IDLE;
  end
endmodule

// File: tb/tb_smg_channel_scheduler.sv
// tb_smg_channel_scheduler: directed scenarios checked against a behavioural display-sharing model
module tb_smg_channel_scheduler;
  localparam int N = 4, W = 20, D = 100, S = 8;
  logic clk = 0, rst = 1, hold = 0;
  logic [N-1:0] ch_valid = '0, ch_urgent = '0;
  logic [N*W-1:0] ch_data = '0;
  logic number_en, busy, idle;
  logic [W-1:0] number;
  logic [1:0] cur_ch;
  int total = 0, bad = 0, cyc = 0, n;
  int load_cyc[$], load_val[$], load_ch[$];
  int m_left, m_cur, m_num, m_shown, m_dwell;
  bit m_idle, m_refresh, m_zero;

  always #5 clk = ~clk;

  smg_channel_scheduler #(.NUM_CH(N), .NUM_W(W), .DWELL_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_urgent(ch_urgent), .ch_data(ch_data),
    .hold(hold), .number_en(number_en), .number(number), .cur_ch(cur_ch), .busy(busy), .idle(idle)
  );

  function automatic int dat(int c);
    return int'(ch_data[c*W +: W]);
  endfunction

  task automatic set_data(int c, int v);
    ch_data[c*W +: W] = W'(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic m_load(int c, int v, bit r, bit z);
    m_left = S + 1;
    m_cur = c;
    m_num = v;
    m_shown = v;
    m_idle = 0;
    m_refresh = r;
    m_zero = z;
    if (!r) m_dwell = 0;
  endtask

  // One clock of the display-sharing rules: load+settle window, idle pick, then dwell priorities
  task automatic m_step();
    int nxt, urg, pick;
    bit selfu;
    nxt = -1; urg = -1; pick = -1;
    if (rst) begin
      m_left = 0; m_cur = 0; m_num = 0; m_shown = 0; m_dwell = 0;
      m_idle = 1; m_refresh = 0; m_zero = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_refresh && !hold && m_dwell < D - 1) m_dwell++;
      if (m_left == 0 && m_zero) m_idle = 1;
    end else if (m_idle) begin
      for (int c = N - 1; c >= 0; c--) if (ch_valid[c]) pick = c;
      if (pick >= 0) m_load(pick, dat(pick), 0, 0);
    end else begin
      for (int k = N; k >= 1; k--) if (ch_valid[(m_cur + k) % N]) nxt = (m_cur + k) % N;
      for (int c = N - 1; c >= 0; c--) if (c != m_cur && ch_valid[c] && ch_urgent[c]) urg = c;
      selfu = ch_urgent[m_cur];
      if (!ch_valid[m_cur]) begin
        if (nxt >= 0) m_load(nxt, dat(nxt), 0, 0);
        else m_load(m_cur, 0, 0, 1);
      end else if (!hold && urg >= 0) m_load(urg, dat(urg), 0, 0);
      else if (dat(m_cur) != m_shown) begin
        m_dwell = hold ? m_dwell : selfu ? 0 : (m_dwell == D - 1 ? m_dwell : m_dwell + 1);
        m_load(m_cur, dat(m_cur), 1, 0);
      end else if (!hold && m_dwell == D - 1) begin
        if (nxt != m_cur) m_load(nxt, dat(nxt), 0, 0);
        else m_dwell = 0;
      end else if (!hold) m_dwell = selfu ? 0 : m_dwell + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
    #1;
    cyc++;
    total++;
    if (number_en !== (m_left == S + 1) || number !== W'(m_num) || cur_ch !== 2'(m_cur) ||
        busy !== (m_left > 0) || idle !== m_idle) begin
      bad++;
      $display("FAIL cycle %0d: en=%b num=%0d ch=%0d busy=%b idle=%b want en=%b num=%0d ch=%0d busy=%b idle=%b",
               cyc, number_en, number, cur_ch, busy, idle, m_left == S + 1, m_num, m_cur, m_left > 0, m_idle);
    end
    if (number_en === 1'b1) begin
      load_cyc.push_back(cyc);
      load_val.push_back(int'(number));
      load_ch.push_back(int'(cur_ch));
    end
  end

  task automatic wait_loads(int want);
    int t = 0;
    while (load_cyc.size() < want && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (load_cyc.size() < want) begin
      bad++;
      total++;
      $display("FAIL wait_loads: got %0d loads want %0d", load_cyc.size(), want);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_idle", idle, 1);
    check("reset_busy", busy, 0);
    check("reset_en", number_en, 0);
    check("reset_number", number, 0);
    check("reset_cur", cur_ch, 0);
    repeat (50) @(negedge clk);
    check("s1_idle", idle, 1);
    check("s1_no_loads", load_cyc.size(), 0);
    check("s1_number", number, 0);
    set_data(0, 1234);
    set_data(2, 567890);
    ch_valid = 4'b0101;
    wait_loads(1);
    check("s1_val", load_val[0], 1234);
    check("s1_ch", load_ch[0], 0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("s1_busy_len", n, 9);
    wait_loads(3);
    check("s2_val1", load_val[1], 567890);
    check("s2_ch1", load_ch[1], 2);
    check("s2_val2", load_val[2], 1234);
    check("s2_ch2", load_ch[2], 0);
    check("s2_gap1", load_cyc[1] - load_cyc[0], 109);
    check("s2_gap2", load_cyc[2] - load_cyc[1], 109);
    set_data(3, 42);
    ch_valid = 4'b1101;
    ch_urgent = 4'b1000;
    wait_loads(4);
    ch_urgent = '0;
    check("s3_val", load_val[3], 42);
    check("s3_ch", load_ch[3], 3);
    check("s3_gap", load_cyc[3] - load_cyc[2], 10);
    wait_loads(5);
    check("s3_rot_ch", load_ch[4], 0);
    check("s3_rot_gap", load_cyc[4] - load_cyc[3], 109);
    hold = 1;
    ch_urgent = 4'b1000;
    repeat (150) @(negedge clk);
    check("s3_hold_noload", load_cyc.size(), 5);
    check("s3_hold_cur", cur_ch, 0);
    hold = 0;
    ch_urgent = '0;
    ch_valid = 4'b0101;
    wait_loads(6);
    check("s4_ch", load_ch[5], 2);
    check("s4_val", load_val[5], 567890);
    repeat (40) @(negedge clk);
    set_data(2, 567891);
    wait_loads(7);
    check("s4_ref_val", load_val[6], 567891);
    check("s4_ref_ch", load_ch[6], 2);
    wait_loads(8);
    check("s4_next_ch", load_ch[7], 0);
    check("s4_deadline", load_cyc[7] - load_cyc[5], 109);
    repeat (20) @(negedge clk);
    set_data(1, 777);
    ch_valid = 4'b0010;
    wait_loads(9);
    check("s5_val", load_val[8], 777);
    check("s5_ch", load_ch[8], 1);
    repeat (20) @(negedge clk);
    ch_valid = '0;
    wait_loads(10);
    check("s5_zero_val", load_val[9], 0);
    check("s5_zero_ch", load_ch[9], 1);
    n = 0;
    while (idle !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s5_idle_delay", n, 9);
    ch_valid = 4'b0010;
    wait_loads(11);
    check("s5_reload_val", load_val[10], 777);
    check("s5_reload_ch", load_ch[10], 1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("s6_idle", idle, 1);
    check("s6_busy", busy, 0);
    check("s6_en", number_en, 0);
    check("s6_number", number, 0);
    check("s6_cur", cur_ch, 0);
    wait_loads(12);
    check("s6_val", load_val[11], 777);
    check("s6_ch", load_ch[11], 1);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
